// File: rtl/can_frame_header_decoder.sv
// CAN / CAN FD header decoder: walks SOF..DLC on destuffed sample-point bits,
// captures identifier and control fields and classifies the frame.
module can_frame_header_decoder #(
  parameter bit         FD_EN           = 1'b1,
  parameter bit         RES_CHECK       = 1'b1,
  parameter logic [6:0] MAX_CLASSIC_LEN = 7'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SP,
  input  logic        RX,
  input  logic        FRAME_END,
  output logic [1:0]  TYPE_FR,
  output logic        IDE,
  output logic [28:0] ID,
  output logic [3:0]  DLC,
  output logic [6:0]  DLEN,
  output logic        BRS,
  output logic        ESI,
  output logic        HDR_VALID,
  output logic        PROT_EXC,
  output logic        BUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_BASE_ID, S_SRR_RTR, S_IDE_B, S_EXT_ID, S_RTR_EXT, S_FDF_R,
    S_RES, S_BRS_B, S_ESI_B, S_R0, S_DLC_B, S_DONE, S_SKIP
  } state_t;

  state_t      state_r, next_state_s;
  logic [4:0]  cnt_r;
  logic [10:0] id11_r;
  logic [17:0] id18_r;
  logic [2:0]  dlc_sh_r;
  logic [3:0]  dlc_full_s;
  logic        rtr_tmp_r, rtr_final_r, ide_tmp_r, fd_tmp_r, brs_tmp_r, esi_tmp_r;
  logic [1:0]  type_fr_r;
  logic        ide_r, brs_r, esi_r, hdr_valid_r, prot_exc_r, busy_r;
  logic [28:0] id_r;
  logic [3:0]  dlc_r;
  logic [6:0]  dlen_r;

  // FD lengths above 8 follow the non-linear CAN FD table; classical saturates.
  function automatic logic [6:0] calc_dlen(input logic fd, input logic rtr, input logic [3:0] dlc);
    logic [6:0] len;
    len = 7'd0;
    if (fd) begin
      case (dlc)
        4'd9:    len = 7'd12;
        4'd10:   len = 7'd16;
        4'd11:   len = 7'd20;
        4'd12:   len = 7'd24;
        4'd13:   len = 7'd32;
        4'd14:   len = 7'd48;
        4'd15:   len = 7'd64;
        default: len = {3'b000, dlc};
      endcase
    end else if (rtr) begin
      len = 7'd0;
    end else if ({3'b000, dlc} > MAX_CLASSIC_LEN) begin
      len = MAX_CLASSIC_LEN;
    end else begin
      len = {3'b000, dlc};
    end
    return len;
  endfunction

  assign dlc_full_s = {dlc_sh_r, RX};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; FRAME_END overrides any sampled bit.
  always_comb begin
    next_state_s = state_r;
    if (FRAME_END) begin
      next_state_s = S_IDLE;
    end else if (SP) begin
      case (state_r)
        S_IDLE:    next_state_s = RX ? S_IDLE : S_BASE_ID;
        S_BASE_ID: next_state_s = (cnt_r == 5'd10) ? S_SRR_RTR : S_BASE_ID;
        S_SRR_RTR: next_state_s = S_IDE_B;
        S_IDE_B:   next_state_s = RX ? S_EXT_ID : S_FDF_R;
        S_EXT_ID:  next_state_s = (cnt_r == 5'd17) ? S_RTR_EXT : S_EXT_ID;
        S_RTR_EXT: next_state_s = S_FDF_R;
        S_FDF_R: begin
          if (FD_EN && RX) begin
            next_state_s = S_RES;
          end else if (ide_tmp_r) begin
            next_state_s = S_R0;
          end else begin
            next_state_s = S_DLC_B;
          end
        end
        S_RES:     next_state_s = (RX && RES_CHECK) ? S_SKIP : S_BRS_B;
        S_BRS_B:   next_state_s = S_ESI_B;
        S_ESI_B:   next_state_s = S_DLC_B;
        S_R0:      next_state_s = S_DLC_B;
        S_DLC_B:   next_state_s = (cnt_r == 5'd3) ? S_DONE : S_DLC_B;
        S_DONE:    next_state_s = S_DONE;
        S_SKIP:    next_state_s = S_SKIP;
        default:   next_state_s = S_IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Field capture, pulses and header output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= 5'd0;
      id11_r      <= 11'd0;
      id18_r      <= 18'd0;
      dlc_sh_r    <= 3'd0;
      rtr_tmp_r   <= 1'b0;
      rtr_final_r <= 1'b0;
      ide_tmp_r   <= 1'b0;
      fd_tmp_r    <= 1'b0;
      brs_tmp_r   <= 1'b0;
      esi_tmp_r   <= 1'b0;
      type_fr_r   <= 2'd0;
      ide_r       <= 1'b0;
      id_r        <= 29'd0;
      dlc_r       <= 4'd0;
      dlen_r      <= 7'd0;
      brs_r       <= 1'b0;
      esi_r       <= 1'b0;
      hdr_valid_r <= 1'b0;
      prot_exc_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else if (FRAME_END) begin
      cnt_r       <= 5'd0;
      busy_r      <= 1'b0;
      hdr_valid_r <= 1'b0;
      prot_exc_r  <= 1'b0;
    end else begin
      hdr_valid_r <= 1'b0;
      prot_exc_r  <= 1'b0;
      if (SP) begin
        case (state_r)
          S_IDLE: begin
            if (!RX) begin
              busy_r    <= 1'b1;
              cnt_r     <= 5'd0;
              ide_tmp_r <= 1'b0;
              fd_tmp_r  <= 1'b0;
              brs_tmp_r <= 1'b0;
              esi_tmp_r <= 1'b0;
            end
          end
          S_BASE_ID: begin
            id11_r <= {id11_r[9:0], RX};
            cnt_r  <= (cnt_r == 5'd10) ? 5'd0 : cnt_r + 5'd1;
          end
          S_SRR_RTR: rtr_tmp_r <= RX;
          S_IDE_B: begin
            ide_tmp_r   <= RX;
            rtr_final_r <= rtr_tmp_r;
          end
          S_EXT_ID: begin
            id18_r <= {id18_r[16:0], RX};
            cnt_r  <= (cnt_r == 5'd17) ? 5'd0 : cnt_r + 5'd1;
          end
          S_RTR_EXT: rtr_final_r <= RX;
          S_FDF_R:   fd_tmp_r <= FD_EN & RX;
          S_RES:     prot_exc_r <= RX & RES_CHECK;
          S_BRS_B:   brs_tmp_r <= RX;
          S_ESI_B:   esi_tmp_r <= RX;
          S_DLC_B: begin
            dlc_sh_r <= {dlc_sh_r[1:0], RX};
            if (cnt_r == 5'd3) begin
              cnt_r       <= 5'd0;
              hdr_valid_r <= 1'b1;
              type_fr_r   <= fd_tmp_r ? 2'd2 : (rtr_final_r ? 2'd1 : 2'd0);
              ide_r       <= ide_tmp_r;
              id_r        <= ide_tmp_r ? {id11_r, id18_r} : {18'd0, id11_r};
              dlc_r       <= dlc_full_s;
              dlen_r      <= calc_dlen(fd_tmp_r, rtr_final_r, dlc_full_s);
              brs_r       <= fd_tmp_r & brs_tmp_r;
              esi_r       <= fd_tmp_r & esi_tmp_r;
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign TYPE_FR   = type_fr_r;
  assign IDE       = ide_r;
  assign ID        = id_r;
  assign DLC       = dlc_r;
  assign DLEN      = dlen_r;
  assign BRS       = brs_r;
  assign ESI       = esi_r;
  assign HDR_VALID = hdr_valid_r;
  assign PROT_EXC  = prot_exc_r;
  assign BUSY      = busy_r;

endmodule
